mac_dot_sequencer: RTL and testbench
====================================

Name: mac_dot_sequencer

Overview:
- Stream-side driver for the 8-bit Dadda/Brent-Kung MAC.
- Accepts operand pairs over a valid/ready stream and drives the MAC's a/b/cin/rst pins.
- Clears the accumulator between dot-product vectors, waits out MAC latency, then returns each vector's 16-bit result, sticky overflow and beat count over a valid/ready result stream.
- Sits between an operand FIFO and the MAC in the accelerator datapath.

Parameters:
MAC_LAT, 1, cycles from operands on mac_a/mac_b until the accumulation is visible on mac_out.
MAX_LEN, 256, maximum beats per vector; a vector reaching this without s_last is force-terminated.
CNT_W, 9, width of beat counter; must satisfy 2^CNT_W > MAX_LEN.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
s_valid  in  1  operand beat valid.
s_ready  out  1  operand beat accepted when s_valid & s_ready.
s_a  in  8  multiplicand.
s_b  in  8  multiplier.
s_last  in  1  final beat of the vector.
mac_a  out  8  to MAC a; 0 when no beat is accepted.
mac_b  out  8  to MAC b; 0 when no beat is accepted.
mac_cin  out  1  to MAC cin; always 0.
mac_rst  out  1  to MAC rst; clears the accumulator.
mac_out  in  16  MAC accumulator.
mac_cout  in  1  MAC carry-out.
m_valid  out  1  result valid.
m_ready  in  1  result consumed when m_valid & m_ready.
m_result  out  16  accumulated sum mod 2^16.
m_ovf  out  1  sticky OR of mac_cout over the vector.
m_trunc  out  1  vector ended by MAX_LEN, not s_last.
m_count  out  CNT_W  beats accepted in the vector.

Behaviour:
- Reset
  - State CLEAR.
  - mac_rst=1, s_ready=0, m_valid=0, m_result=0, m_ovf=0, m_trunc=0, m_count=0, mac_a=mac_b=0, mac_cin=0.
  - Reset mid-vector discards the partial vector, including any captured-but-unread result.
- Combinational pin drive
  - mac_a/mac_b = s_a/s_b when a beat is accepted this cycle, else 0 (zero product holds the accumulator).
  - mac_rst=1 only in CLEAR.
- States
  - CLEAR: one cycle. Clears counters and flags. Next state ACCUM.
  - ACCUM: s_ready=1. Each accepted beat increments the count. mac_cout is ORed into the ovf flag every ACCUM/DRAIN cycle, one cycle after the beat. A beat with s_last, or the beat making count==MAX_LEN, goes to DRAIN; the latter also sets trunc.
  - DRAIN: s_ready=0. Wait MAC_LAT cycles. On the final cycle, capture mac_out into m_result and the final mac_cout into ovf. Next state RESULT.
  - RESULT: m_valid=1. Outputs are stable until m_ready. On handshake go to CLEAR; m_valid drops the next cycle.
- Throughput and latency
  - Steady state: 1 beat/cycle.
  - Per-vector overhead: MAC_LAT + 1 (CLEAR) cycles + result handshake.
  - Result valid MAC_LAT+1 cycles after the last beat is accepted.
- Boundaries
  - Length-1 vector (s_last on first beat) is legal.
  - s_valid low in ACCUM: zero operands are driven and the count holds.
  - s_last together with count reaching MAX_LEN: trunc=0.
  - Arithmetic wraps mod 2^16; the wrap is reported only via m_ovf.
  - m_ready asserted before m_valid has no effect.

Decomposition:
- Shared package mac_seq_pkg holds:
  - state enum {CLEAR, ACCUM, DRAIN, RESULT};
  - operand width 8 and result width 16 constants;
  - the CNT_W derivation function.
- No sub-module is required.
- The drain delay counter may be factored as mac_seq_lat_timer if MAC_LAT>1 variants are built.
- The MAC itself is instantiated alongside this block by the parent, not inside it.

Test Plan:
- Beats (15,15),(3,4,last), m_ready=1 → m_result=237, m_count=2, m_ovf=0, m_valid 2 cycles after last beat.
- Beats (255,255),(255,255,last) → m_result=64514, m_ovf=1.
- Single beat (128,64,last) → m_result=8192, m_count=1; next vector (0,127,last) → 0 (clear verified).
- Result backpressure: m_ready=0 for 5 cycles with s_valid held → s_ready=0, m_result stable, no beat lost; after release the next vector is correct.
- rst after 2 beats of (100,100) → all outputs zero; new vector (100,100,last) → 10000, m_count=1.
- MAX_LEN=4, 5 beats of (1,1), no s_last → first result 4, m_trunc=1; 5th beat starts a new vector giving result 1 after its s_last.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// Shared types and widths for the MAC dot-product sequencer.
// Holds the sequencer state encoding and the beat-counter width helper.
package mac_seq_pkg;

    localparam int OP_W  = 8;
    localparam int RES_W = 16;

    typedef enum logic [1:0] {
        CLEAR,
        ACCUM,
        DRAIN,
        RESULT
    } seq_state_e;

    // Smallest counter width that can hold the value max_len itself.
    function automatic int cnt_w_for(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/mac_dot_sequencer.sv
// Streams operand pairs into an external accumulating MAC, one vector at
// a time, and returns each vector's sum, sticky overflow and beat count.
module mac_dot_sequencer
    import mac_seq_pkg::*;
#(
    parameter int MAC_LAT = 1,
    parameter int MAX_LEN = 256,
    parameter int CNT_W   = cnt_w_for(MAX_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [OP_W-1:0]  s_a,
    input  logic [OP_W-1:0]  s_b,
    input  logic             s_last,
    output logic [OP_W-1:0]  mac_a,
    output logic [OP_W-1:0]  mac_b,
    output logic             mac_cin,
    output logic             mac_rst,
    input  logic [RES_W-1:0] mac_out,
    input  logic             mac_cout,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [RES_W-1:0] m_result,
    output logic             m_ovf,
    output logic             m_trunc,
    output logic [CNT_W-1:0] m_count
);

    localparam int LAT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    seq_state_e       r_state;
    seq_state_e       w_next;
    logic [CNT_W-1:0] r_count;
    logic [LAT_W-1:0] r_lat;
    logic [RES_W-1:0] r_result;
    logic             r_ovf;
    logic             r_trunc;

    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_hit_max;
    logic             w_lat_done;

    assign s_ready    = (r_state == ACCUM) && !rst;
    assign w_accept   = s_valid && s_ready;
    assign w_cnt_inc  = r_count + CNT_W'(1);
    assign w_hit_max  = (w_cnt_inc == CNT_W'(MAX_LEN));
    assign w_lat_done = (r_lat == LAT_W'(MAC_LAT - 1));

    // Idle cycles feed a zero product so the accumulator holds its value.
    assign mac_a   = w_accept ? s_a : '0;
    assign mac_b   = w_accept ? s_b : '0;
    assign mac_cin = 1'b0;
    assign mac_rst = (r_state == CLEAR) || rst;

    assign m_valid  = (r_state == RESULT);
    assign m_result = r_result;
    assign m_ovf    = r_ovf;
    assign m_trunc  = r_trunc;
    assign m_count  = r_count;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            CLEAR: begin
                w_next = ACCUM;
            end
            ACCUM: begin
                if (w_accept && (s_last || w_hit_max)) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_lat_done) begin
                    w_next = RESULT;
                end
            end
            RESULT: begin
                if (m_ready) begin
                    w_next = CLEAR;
                end
            end
            default: begin
                w_next = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= CLEAR;
            r_count  <= '0;
            r_lat    <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_trunc  <= 1'b0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                CLEAR: begin
                    r_count  <= '0;
                    r_lat    <= '0;
                    r_result <= '0;
                    r_ovf    <= 1'b0;
                    r_trunc  <= 1'b0;
                end
                ACCUM: begin
                    r_ovf <= r_ovf | mac_cout;
                    if (w_accept) begin
                        r_count <= w_cnt_inc;
                        // An explicit last on the final allowed beat is a normal end.
                        if (!s_last && w_hit_max) begin
                            r_trunc <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    r_ovf <= r_ovf | mac_cout;
                    r_lat <= r_lat + LAT_W'(1);
                    if (w_lat_done) begin
                        r_result <= mac_out;
                    end
                end
                RESULT: begin
                    r_lat <= '0;
                end
                default: begin
                    r_lat <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer with a behavioural MAC and a vector-level
// reference model of sums, overflow, truncation and result latency.
module tb_mac_dot_sequencer;

    localparam int MAC_LAT = 1;
    localparam int MAX_LEN = 4;
    localparam int CNT_W   = 3;

    typedef struct {
        int res;
        int ovf;
        int trunc;
        int cnt;
        int endc;
    } rec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [7:0]       s_a = '0;
    logic [7:0]       s_b = '0;
    logic             s_last = 1'b0;
    logic [7:0]       mac_a;
    logic [7:0]       mac_b;
    logic             mac_cin;
    logic             mac_rst;
    logic [15:0]      mac_out = '0;
    logic             mac_cout = 1'b0;
    logic             m_valid;
    logic             m_ready;
    logic [15:0]      m_result;
    logic             m_ovf;
    logic             m_trunc;
    logic [CNT_W-1:0] m_count;

    logic mr_main = 1'b1;
    logic mr_rnd  = 1'b0;
    logic rnd_mode = 1'b0;
    assign m_ready = rnd_mode ? mr_rnd : mr_main;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    rec_t exp_q[$];
    rec_t got_q[$];
    int   cur_sum = 0;
    int   cur_n = 0;
    bit   prev_valid = 1'b0;

    always #5 clk = ~clk;

    mac_dot_sequencer #(
        .MAC_LAT (MAC_LAT),
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_a      (s_a),
        .s_b      (s_b),
        .s_last   (s_last),
        .mac_a    (mac_a),
        .mac_b    (mac_b),
        .mac_cin  (mac_cin),
        .mac_rst  (mac_rst),
        .mac_out  (mac_out),
        .mac_cout (mac_cout),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_result (m_result),
        .m_ovf    (m_ovf),
        .m_trunc  (m_trunc),
        .m_count  (m_count)
    );

    // The external MAC: one-cycle accumulate with carry-out of each add.
    always @(posedge clk) begin
        if (mac_rst) begin
            mac_out  <= '0;
            mac_cout <= 1'b0;
        end else begin
            {mac_cout, mac_out} <= 17'(mac_out) + 17'(mac_a) * 17'(mac_b)
                                   + 17'(mac_cin);
        end
    end

    always @(posedge clk) begin
        #1;
        mr_rnd = ($urandom_range(0, 2) != 0);
    end

    task automatic chk(input string name, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        bit   hs;
        rec_t e;
        cyc++;
        hs = s_valid && s_ready;
        chk("mac_cin", mac_cin, 0);
        chk("mac_a", mac_a, hs ? s_a : 8'd0);
        chk("mac_b", mac_b, hs ? s_b : 8'd0);
        if (rst) begin
            cur_sum = 0;
            cur_n = 0;
            exp_q.delete();
            prev_valid = 1'b0;
        end else begin
            if (m_valid) chk("s_ready_in_result", s_ready, 0);
            if (hs) begin
                cur_sum += int'(s_a) * int'(s_b);
                cur_n++;
                if (s_last || cur_n == MAX_LEN) begin
                    e.res   = cur_sum % 65536;
                    e.ovf   = (cur_sum >= 65536) ? 1 : 0;
                    e.trunc = (!s_last) ? 1 : 0;
                    e.cnt   = cur_n;
                    e.endc  = cyc;
                    exp_q.push_back(e);
                    cur_sum = 0;
                    cur_n = 0;
                end
            end
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    chk("m_valid_spurious", m_valid, 0);
                end else begin
                    e = exp_q[0];
                    if (!prev_valid) chk("latency", cyc - e.endc, MAC_LAT + 1);
                    chk("m_result", m_result, e.res);
                    chk("m_ovf", m_ovf, e.ovf);
                    chk("m_trunc", m_trunc, e.trunc);
                    chk("m_count", m_count, e.cnt);
                    if (m_ready) begin
                        e.res   = m_result;
                        e.ovf   = m_ovf;
                        e.trunc = m_trunc;
                        e.cnt   = m_count;
                        got_q.push_back(e);
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_valid = m_valid && !m_ready;
        end
    end

    task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input bit last);
        int n = 0;
        s_valid = 1'b1;
        s_a = a;
        s_b = b;
        s_last = last;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 200) begin
                chk("beat_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_a = '0;
        s_b = '0;
        s_last = 1'b0;
    endtask

    task automatic wait_result(output rec_t r);
        int n = 0;
        while (got_q.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (got_q.size() == 0) begin
            chk("result_timeout", 0, 1);
            r = '{res: -1, ovf: -1, trunc: -1, cnt: -1, endc: 0};
        end else begin
            r = got_q.pop_front();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rec_t r;
        logic [7:0] a;
        logic [7:0] b;
        int len;
        int n;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mac_rst", mac_rst, 1);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_result", m_result, 0);
        chk("rst_m_ovf", m_ovf, 0);
        chk("rst_m_trunc", m_trunc, 0);
        chk("rst_m_count", m_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        send_beat(8'd15, 8'd15, 1'b0);
        send_beat(8'd3, 8'd4, 1'b1);
        wait_result(r);
        chk("t1_res", r.res, 237);
        chk("t1_cnt", r.cnt, 2);
        chk("t1_ovf", r.ovf, 0);

        send_beat(8'd255, 8'd255, 1'b0);
        send_beat(8'd255, 8'd255, 1'b1);
        wait_result(r);
        chk("t2_res", r.res, 64514);
        chk("t2_ovf", r.ovf, 1);

        send_beat(8'd128, 8'd64, 1'b1);
        wait_result(r);
        chk("t3_res", r.res, 8192);
        chk("t3_cnt", r.cnt, 1);
        send_beat(8'd0, 8'd127, 1'b1);
        wait_result(r);
        chk("t3_clear_res", r.res, 0);
        chk("t3_clear_ovf", r.ovf, 0);

        mr_main = 1'b0;
        send_beat(8'd7, 8'd9, 1'b1);
        s_valid = 1'b1;
        s_a = 8'd2;
        s_b = 8'd3;
        s_last = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("bp_s_ready", s_ready, 0);
        end
        chk("bp_m_valid", m_valid, 1);
        chk("bp_m_result", m_result, 63);
        @(posedge clk);
        #1;
        mr_main = 1'b1;
        send_beat(8'd2, 8'd3, 1'b0);
        send_beat(8'd5, 8'd5, 1'b1);
        wait_result(r);
        chk("bp_first_res", r.res, 63);
        wait_result(r);
        chk("bp_next_res", r.res, 31);
        chk("bp_next_cnt", r.cnt, 2);

        send_beat(8'd100, 8'd100, 1'b0);
        send_beat(8'd100, 8'd100, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_m_count", m_count, 0);
        chk("midrst_m_result", m_result, 0);
        chk("midrst_s_ready", s_ready, 0);
        chk("midrst_mac_rst", mac_rst, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_beat(8'd100, 8'd100, 1'b1);
        wait_result(r);
        chk("midrst_res", r.res, 10000);
        chk("midrst_cnt", r.cnt, 1);

        for (int i = 0; i < 4; i++) send_beat(8'd1, 8'd1, 1'b0);
        send_beat(8'd1, 8'd1, 1'b1);
        wait_result(r);
        chk("trunc_res", r.res, 4);
        chk("trunc_flag", r.trunc, 1);
        chk("trunc_cnt", r.cnt, 4);
        wait_result(r);
        chk("after_trunc_res", r.res, 1);
        chk("after_trunc_flag", r.trunc, 0);

        for (int i = 0; i < 3; i++) send_beat(8'd1, 8'd1, 1'b0);
        send_beat(8'd2, 8'd2, 1'b1);
        wait_result(r);
        chk("last_at_max_res", r.res, 7);
        chk("last_at_max_trunc", r.trunc, 0);
        chk("last_at_max_cnt", r.cnt, 4);

        rnd_mode = 1'b1;
        for (int v = 0; v < 300; v++) begin
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                n = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
                for (int g = 0; g < n; g++) begin
                    s_a = 8'($urandom);
                    s_b = 8'($urandom);
                    s_last = 1'($urandom);
                    @(posedge clk);
                    #1;
                end
                a = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
                b = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
                send_beat(a, b, k == len - 1);
            end
            got_q.delete();
        end
        n = 0;
        while ((exp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rnd_leftover", exp_q.size(), 0);
        rnd_mode = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
